bsearch_engine: RTL
===================

# bsearch_engine

Parametrised binary-search engine over an external synchronous-read memory holding ascending-sorted unsigned words. It generalises the board-level search block in three ways: data width and depth are parameters, the memory is external, and a lower-bound mode returns an insertion point. A search runs on a level-sensitive start, and the result is held until start drops. It sits between a sorted RAM (ROM or loaded buffer) and display/status logic in board top levels.

## Interface
- DATA_W, default 8: width of memory words and target, unsigned.
- ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries, all valid and sorted ascending (duplicates allowed).
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE and clears all registers.
- start  input  1  level request; sampled only in IDLE; must drop to re-arm after DONE.
- target  input  DATA_W  search key; latched on the start-accept edge.
- mode  input  1  0 = exact match, 1 = lower bound (first index with mem >= target); latched with target.
- mem_addr  output  ADDR_W  read address to the RAM.
- mem_rdata  input  DATA_W  RAM data; valid the cycle after mem_addr is presented (1-cycle synchronous read).
- busy  output  1  high in ISSUE and CMP.
- done  output  1  high in DONE.
- found  output  1  in DONE: exact hit (mode 0), or lower bound < DEPTH (mode 1).
- not_found  output  1  in DONE: complement of found; never high together with found.
- index  output  ADDR_W  result index; holds its last value in IDLE.
- probes  output  ADDR_W+1  number of compares in the current or last search.

## Operation
- Registers: lo and hi, each ADDR_W+1 bits, half-open range [lo,hi). mid = lo + ((hi-lo)>>1). mem_addr = mid[ADDR_W-1:0] at all times (combinational from lo/hi).
- IDLE: if start, latch target and mode; lo=0, hi=DEPTH, probes=0 -> ISSUE.
- ISSUE: if lo >= hi -> DONE with the lookup-ended result. Otherwise -> CMP. lo and hi are unchanged, so mem_addr stays stable through CMP.
- CMP: probes += 1; compare mem_rdata against the latched target, unsigned:
  - Mode 0, equal: index = mid, found -> DONE.
  - mem_rdata < target: lo = mid+1 -> ISSUE.
  - Otherwise: hi = mid -> ISSUE.
  - Mode 1 never exits from CMP; equal is treated as the "otherwise" case (hi = mid).
- Lookup-ended result: index = lo[ADDR_W-1:0].
  - Mode 0: not_found; index is the insertion point.
  - Mode 1: found if lo < DEPTH, else not_found with index = 0.
- DONE: done=1 and result outputs held. When start = 0 -> IDLE: done/found/not_found clear; index and probes hold.
- start held high through DONE never retriggers a search.

## Timing
- Reset values: state IDLE, lo=hi=0, mem_addr=0, busy=done=found=not_found=0, index=0, probes=0.
- Reset mid-search aborts asynchronously; no done pulse, and no memory read is considered outstanding.
- Each probe costs 2 cycles (ISSUE, CMP).
- Let E0 be the edge where start is accepted in IDLE. For k probes, done is high after edge E0+2k for an exact hit, else after edge E0+2k+1.
- Maximum probes = ADDR_W+1 (6 for the default), so worst-case latency is 2*ADDR_W+3 edges.
- busy is high from the edge after E0 until the edge that enters DONE.
- DONE -> IDLE takes 1 edge after start is sampled low. A new search needs start low for at least one edge in DONE, then high again in IDLE.
- target and mode changes during a search have no effect.

## Test plan
All cases use defaults, mem[i] = 2i+1 (values 1..63), and a 1-cycle-latency RAM model.
- Exact, target 11 -> found=1, index=5, probes=5, done after E0+10, mem_addr sequence 16,8,4,6,5.
- Exact, target 12 -> not_found=1, found=0, index=6, probes=5, done after E0+11.
- Lower bound, target 12 -> found=1, index=6; target 64 -> not_found=1, index=0, probes=5; target 0 -> found=1, index=0.
- Exact, target 63 -> found, index=31; target 1 -> found, index=0. Checks both ends and no wrap of mid or lo.
- start held high across DONE for 20 cycles -> exactly one search; drop start for 1 cycle, raise again with target 55 -> second search, found, index=27.
- Assert reset during CMP of probe 3 -> all outputs 0 immediately. After release with start still high -> new search from lo=0, hi=32 with a correct result.

Source files
------------

// File: rtl/bsearch_if.sv
// Request/result and memory-port bundle for the binary-search engine.
interface bsearch_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [DATA_W-1:0] target;
  logic              mode;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              found;
  logic              not_found;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W:0]   probes;

  // Requester side: issues searches, serves memory reads, consumes results.
  modport master (
    output start, target, mode, mem_rdata,
    input  mem_addr, busy, done, found, not_found, index, probes
  );

  // Engine side.
  modport slave (
    input  start, target, mode, mem_rdata,
    output mem_addr, busy, done, found, not_found, index, probes
  );
endinterface

// File: rtl/bsearch_engine.sv
// Binary search over an external 1-cycle synchronous-read RAM holding
// ascending-sorted unsigned words. Mode 0 finds an exact match, mode 1
// returns the lower bound (first index with mem >= target).
module bsearch_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic      clk,
  input  logic      reset,
  bsearch_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_CMP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q,  state_d;
  logic [ADDR_W:0]   lo_q,     lo_d;
  logic [ADDR_W:0]   hi_q,     hi_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic              mode_q,   mode_d;
  logic [ADDR_W-1:0] index_q,  index_d;
  logic [ADDR_W:0]   probes_q, probes_d;
  logic              found_q,  found_d;
  logic              nf_q,     nf_d;
  logic [ADDR_W:0]   mid;

  // Probe point of the half-open range [lo,hi); written to avoid overflow of lo+hi.
  always_comb begin
    mid = lo_q + ((hi_q - lo_q) >> 1);
  end

  assign bus.mem_addr  = mid[ADDR_W-1:0];
  assign bus.busy      = (state_q == S_ISSUE) || (state_q == S_CMP);
  assign bus.done      = (state_q == S_DONE);
  assign bus.found     = found_q;
  assign bus.not_found = nf_q;
  assign bus.index     = index_q;
  assign bus.probes    = probes_q;

  // Next-state and datapath update for the search sequencer.
  always_comb begin
    // NOTE: every _d defaults to its _q so no path through the case can infer a latch.
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    target_d = target_q;
    mode_d   = mode_q;
    index_d  = index_q;
    probes_d = probes_q;
    found_d  = found_q;
    nf_d     = nf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          target_d = bus.target;
          mode_d   = bus.mode;
          lo_d     = '0;
          hi_d     = DEPTH;
          probes_d = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (lo_q >= hi_q) begin
          // Range exhausted: lo is the insertion point / lower bound.
          index_d = lo_q[ADDR_W-1:0];
          if (mode_q && (lo_q < DEPTH)) begin
            found_d = 1'b1;
          end else begin
            nf_d = 1'b1;
            if (mode_q) index_d = '0;
          end
          state_d = S_DONE;
        end else begin
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        probes_d = probes_q + ONE;
        if (!mode_q && (bus.mem_rdata == target_q)) begin
          index_d = mid[ADDR_W-1:0];
          found_d = 1'b1;
          state_d = S_DONE;
        end else if (bus.mem_rdata < target_q) begin
          lo_d    = mid + ONE;
          state_d = S_ISSUE;
        end else begin
          hi_d    = mid;
          state_d = S_ISSUE;
        end
      end
      default: begin
        // S_DONE: hold the result until the requester drops start.
        if (!bus.start) begin
          found_d = 1'b0;
          nf_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State registers; reset aborts any search in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      target_q <= '0;
      mode_q   <= 1'b0;
      index_q  <= '0;
      probes_q <= '0;
      found_q  <= 1'b0;
      nf_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      index_q  <= index_d;
      probes_q <= probes_d;
      found_q  <= found_d;
      nf_q     <= nf_d;
    end
  end

endmodule
